servant_uart_host_tx: RTL and testbench
=======================================

Name: servant_uart_host_tx

Overview:
- Host-side serial transmitter that drives the SoC's serial data input (`i_data` on the servant top).
- Accepts bytes from a bench or host over a valid/ready stream and buffers them in a small FIFO.
- Serializes each byte as an 8N1 frame: idle high, start 0, 8 data bits LSB first, stop 1, each bit lasting CLKS_PER_BIT clocks.
- Is the sending end of the link the SoC core receives on, and is used in simulation tops and FPGA wrappers to feed input to the target.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte buffer depth; must be a power of 2 and at least 2.

Ports:
- wb_clk  input  1  system clock; all logic on the rising edge.
- wb_rst  input  1  reset, synchronous and active-high.
- i_tdata  input  8  byte to send.
- i_tvalid  input  1  i_tdata is valid.
- o_tready  output  1  FIFO can accept a byte; high when not full.
- o_tx  output  1  serial line; connect to the SoC i_data; idles high.
- o_busy  output  1  a frame is in progress, or the FIFO is non-empty.
- o_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (wb_rst high at a rising edge):
  - o_tx=1, o_tready=1, o_busy=0, o_level=0.
  - FSM goes to IDLE; FIFO is flushed; baud counter and bit index are cleared.
  - Reset mid-frame aborts the frame: o_tx is 1 after that edge and the partial byte is lost.
- Handshake:
  - A byte is pushed on an edge where i_tvalid && o_tready.
  - o_tready is registered and equals !full.
  - i_tvalid while full is ignored; the byte is not consumed and the source must hold it.
  - Push and pop on the same edge leave o_level unchanged.
- FSM states: IDLE, START, DATA, STOP.
- Baud counter: bcnt counts 0..CLKS_PER_BIT-1; a bit ends when bcnt==CLKS_PER_BIT-1.
- IDLE:
  - o_tx=1.
  - If the FIFO is non-empty: pop into the shift register, bcnt=0, go to START.
  - Latency: a byte pushed at edge N into an empty FIFO with the FSM idle is popped at edge N+1; o_tx goes low from edge N+1.
- START: o_tx=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
- DATA:
  - o_tx = shift register bit 0, for CLKS_PER_BIT clocks per bit.
  - At the end of each bit: shift right and increment the index.
  - After bit 7, go to STOP.
- STOP: o_tx=1 for CLKS_PER_BIT clocks. At the end of the stop bit:
  - If the FIFO is non-empty: pop and go directly to START. No idle gap, so back-to-back frames are exactly 10*CLKS_PER_BIT clocks apart.
  - Otherwise go to IDLE.
- Output timing: o_tx is driven from a flop; no combinational path from i_tvalid or i_tdata to o_tx.
- o_busy = (state != IDLE) || (o_level != 0), registered; no combinational path from inputs.
- FIFO pointers:
  - $clog2(FIFO_DEPTH)+1 bits wide; they wrap modulo 2*FIFO_DEPTH.
  - full = MSBs differ and the lower bits are equal; empty = pointers equal.
- Frame length is 10*CLKS_PER_BIT clocks, with no drift across consecutive frames.

Decomposition:
- Shared package (servant_uart_pkg):
  - state enum: IDLE, START, DATA, STOP.
  - FRAME_BITS=10, DATA_BITS=8 constants.
  - Reused by the matching receiver model.
- Sub-module servant_uart_fifo:
  - Synchronous FIFO with push/pop, full/empty and level, parameterized by width (8) and depth.
  - The top holds the FSM, baud counter and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset values: hold wb_rst 2 cycles, then release → o_tx=1, o_tready=1, o_busy=0, o_level=0, and o_tx stays 1 for 50 cycles.
- Single byte: push 0xA5 at edge N →
  - o_tx=0 over edges N+1..N+4.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Stop bit 1 for 4 cycles; o_busy drops at edge N+41.
- Back-to-back: push 0x00, 0xFF, 0x55 consecutively → three frames, start bits 40 clocks apart, no idle gap; a line sampler decodes exactly 0x00, 0xFF, 0x55.
- Full FIFO:
  - Hold i_tvalid with bytes 0x01..0x06 → o_tready deasserts once the FIFO holds 4 bytes while the first frame is in flight.
  - The source stalls; all 6 bytes are eventually sent, in order.
  - o_level never exceeds 4.
- Reset mid-frame: assert wb_rst during DATA bit 3 of 0xC3 with 2 bytes queued → o_tx=1 the next cycle, o_level=0, and no further start bit occurs.
- Simultaneous push/pop: push exactly on the STOP→START pop edge with o_level=2 → o_level stays 2 and the byte order is preserved.

Source files
------------

// File: rtl/servant_uart_pkg.sv
// rtl/servant_uart_pkg.sv - shared UART framing types and constants
package servant_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  function automatic int frame_clks(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/servant_uart_fifo.sv
// rtl/servant_uart_fifo.sv - synchronous FIFO with wrap-bit pointers and occupancy
module servant_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/servant_uart_host_tx.sv
// rtl/servant_uart_host_tx.sv - buffered 8N1 serial transmitter feeding the SoC data input
module servant_uart_host_tx
  import servant_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst,
  input  logic [7:0]                    i_tdata,
  input  logic                          i_tvalid,
  output logic                          o_tready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          push, pop, full, empty, bit_end;
  logic [7:0]    head;

  assign push    = i_tvalid && !full;
  assign bit_end = (bcnt_q == BCNT_LAST);

  servant_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (wb_clk),
    .rst_i   (wb_rst),
    .push_i  (push),
    .wdata_i (i_tdata),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (o_level)
  );

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bcnt_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bcnt_d  = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Popping straight into START keeps consecutive frames gap-free.
        if (bit_end) begin
          bcnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx     = tx_q;
  assign o_tready = !full;
  assign o_busy   = (state_q != IDLE) || (o_level != '0);

endmodule

// File: tb/tb_servant_uart_host_tx.sv
// tb/tb_servant_uart_host_tx.sv - self-checking bench against a frame-timeline reference model
module tb_servant_uart_host_tx;

  localparam int CPB        = 4;
  localparam int DEPTH      = 4;
  localparam int FRAME_CLKS = 10 * CPB;

  logic       wb_clk = 1'b0;
  logic       wb_rst;
  logic [7:0] i_tdata;
  logic       i_tvalid;
  logic       o_tready, o_tx, o_busy;
  logic [2:0] o_level;

  servant_uart_host_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_level  (o_level)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_err    = 0;
  int ncyc     = 0;

  // Reference model: a byte queue plus position inside the current frame.
  logic [7:0] mq[$];
  logic [7:0] done_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_cur;
  bit         m_act = 0;
  int         m_t   = 0;
  bit         push_ok = 0;

  bit         rx_on = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  int         max_lvl = 0;
  bit         saw_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic tick();
    bit pop_now;
    bit rst_now;
    @(posedge wb_clk);
    ncyc++;
    rst_now = wb_rst;
    pop_now = 0;
    push_ok = 0;
    if (rst_now) begin
      mq.delete();
      m_act = 0;
      m_t   = 0;
    end else begin
      if (!m_act) begin
        if (mq.size() > 0) pop_now = 1;
      end else if (m_t == FRAME_CLKS - 1) begin
        done_q.push_back(m_cur);
        if (mq.size() > 0) pop_now = 1;
        else m_act = 0;
      end else begin
        m_t++;
      end
      push_ok = i_tvalid && (mq.size() < DEPTH);
      if (pop_now) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_t   = 0;
      end
      if (push_ok) mq.push_back(i_tdata);
    end
    #1;
    check("tx",     32'(o_tx),     32'(m_act ? frame_bit(m_cur, m_t / CPB) : 1'b1));
    check("level",  32'(o_level),  32'(mq.size()));
    check("tready", 32'(o_tready), 32'(mq.size() < DEPTH));
    check("busy",   32'(o_busy),   32'(m_act || (mq.size() > 0)));
    if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
    if (!o_tready) saw_stall = 1;
    // Independent line sampler: mid-bit sampling from the detected start edge.
    if (rst_now) begin
      rx_on = 0;
    end else if (!rx_on) begin
      if (o_tx == 1'b0) begin
        rx_on  = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB) == CPB / 2) begin
        if (rx_cnt / CPB <= 8) begin
          rx_byte[rx_cnt / CPB - 1] = o_tx;
        end else begin
          check("stop_bit", 32'(o_tx), 32'd1);
          rx_q.push_back(rx_byte);
          rx_on = 0;
        end
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard;
    i_tvalid = 1'b1;
    i_tdata  = b;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!push_ok && guard < 2000);
    if (!push_ok) check("push_timeout", 32'd0, 32'd1);
    i_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_act || mq.size() > 0) && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) check("drain_timeout", 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  task automatic compare_rx();
    check("rx_count", 32'(rx_q.size()), 32'(done_q.size()));
    for (int i = 0; i < rx_q.size() && i < done_q.size(); i++)
      check("rx_byte", 32'(rx_q[i]), 32'(done_q[i]));
    rx_q.delete();
    done_q.delete();
  endtask

  initial begin
    int n0;
    int guard;
    wb_rst   = 1'b1;
    i_tvalid = 1'b0;
    i_tdata  = 8'h00;

    tick();
    tick();
    wb_rst = 1'b0;
    tick();
    check("rst_tx",     32'(o_tx),     32'd1);
    check("rst_tready", 32'(o_tready), 32'd1);
    check("rst_busy",   32'(o_busy),   32'd0);
    check("rst_level",  32'(o_level),  32'd0);
    repeat (50) tick();

    // Single byte: busy drops 41 edges after the push edge.
    push_byte(8'hA5);
    n0 = ncyc;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (o_busy && guard < 200);
    check("single_busy_drop", 32'(ncyc - n0), 32'd41);
    repeat (5) tick();
    check("single_rx_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("single_rx", 32'(rx_q[0]), 32'hA5);
    compare_rx();

    // Back-to-back frames
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    drain();
    check("b2b_n", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("b2b_0", 32'(rx_q[0]), 32'h00);
      check("b2b_1", 32'(rx_q[1]), 32'hFF);
      check("b2b_2", 32'(rx_q[2]), 32'h55);
    end
    compare_rx();

    // Full FIFO with a stalled source
    max_lvl   = 0;
    saw_stall = 0;
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    drain();
    check("full_stall_seen", 32'(saw_stall), 32'd1);
    check("full_max_level_le_depth", 32'(max_lvl <= DEPTH), 32'd1);
    check("full_max_level", 32'(max_lvl), 32'(DEPTH));
    check("full_rx_n", 32'(rx_q.size()), 32'd6);
    compare_rx();

    // Simultaneous push and pop at the stop-to-start edge
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    guard = 0;
    while (!(m_act && m_t == FRAME_CLKS - 1) && guard < 200) begin
      tick();
      guard++;
    end
    check("simul_level_before", 32'(o_level), 32'd2);
    i_tvalid = 1'b1;
    i_tdata  = 8'h44;
    tick();
    i_tvalid = 1'b0;
    check("simul_level_after", 32'(o_level), 32'd2);
    drain();
    check("simul_rx_n", 32'(rx_q.size()), 32'd4);
    if (rx_q.size() == 4) check("simul_rx_last", 32'(rx_q[3]), 32'h44);
    compare_rx();

    // Reset during data bit 3 with two bytes queued
    push_byte(8'hC3);
    push_byte(8'hAA);
    push_byte(8'hBB);
    guard = 0;
    while (!(m_act && m_t == 4 * CPB + 1) && guard < 200) begin
      tick();
      guard++;
    end
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    check("midrst_tx",    32'(o_tx),    32'd1);
    check("midrst_level", 32'(o_level), 32'd0);
    repeat (60) tick();
    check("midrst_no_frame", 32'(rx_q.size()), 32'd0);
    compare_rx();

    // Randomized traffic with random source gaps
    for (int c = 0; c < 600; c++) begin
      if (!i_tvalid && $urandom_range(0, 3) == 0) begin
        i_tvalid = 1'b1;
        i_tdata  = 8'($urandom);
      end
      tick();
      if (push_ok) i_tvalid = 1'b0;
    end
    i_tvalid = 1'b0;
    drain();
    compare_rx();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
